// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg: funct3 width codes, LSU FSM state type, legality helper.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Unsigned widths only exist for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_align: load lane extract/extend and store lane merge.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [SIZE-1:0] rdata_i,
  input  logic [SIZE-1:0] base_i,
  input  logic [SIZE-1:0] wdata_i,
  output logic [SIZE-1:0] load_o,
  output logic [SIZE-1:0] merge_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata_i[{offset_i, 3'b000} +: 8];
  assign lane_h = rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    load_o  = rdata_i;
    merge_o = base_i;
    case (funct3_i)
      F3_B: begin
        load_o = {{(SIZE-8){lane_b[7]}}, lane_b};
        merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      F3_H: begin
        load_o = {{(SIZE-16){lane_h[15]}}, lane_h};
        merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      F3_BU: load_o = {{(SIZE-8){1'b0}}, lane_b};
      F3_HU: load_o = {{(SIZE-16){1'b0}}, lane_h};
      F3_W:  merge_o = wdata_i;
      default: load_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit: single-port RAM LSU, RMW for sub-word stores.     |
// | Optional LSU_MISALIGN_CHECK_EN flags misaligned H/W. Rev 1.0       |
// +--------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int MEM_DEPTH = 1024,
  parameter  int SIZE      = 32,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [SIZE-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [SIZE-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [SIZE-1:0]   ram_data_in,
  output logic              ram_wren,
  input  logic [SIZE-1:0]   ram_data_out
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [SIZE-1:0]   wdata_q, wdata_d;
  logic [SIZE-1:0]   word_q, word_d;
  logic [SIZE-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [SIZE-1:0]   load_data;
  logic [SIZE-1:0]   merge_data;
  logic              req_misalign;
  logic              req_bad;
  logic              unused_addr_hi;

  // Address bits above the RAM index wrap silently.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
                      || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
`else
  assign req_misalign = 1'b0;
`endif

  assign req_bad = !f3_legal(req_we, req_funct3) || req_misalign;

  lsu_align #(.SIZE(SIZE)) u_align (
    .funct3_i (f3_q),
    .offset_i (addr_q[1:0]),
    .rdata_i  (ram_data_out),
    .base_i   (word_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (req_we && req_funct3 == F3_W) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        word_d = ram_data_out;
        if (we_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_data;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset gates the write strobe directly so a reset in WR aborts the store.
  assign ram_wren    = (state_q == WR) && !reset;
  assign ram_address = addr_q[ADDR_W+1:2];
  assign ram_data_in = merge_data;
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_load_store_unit: directed vector bench with a behavioural RAM.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data_in;
  logic              ram_wren;
  logic [31:0]       ram_data_out;

  logic [31:0] mem [0:MEM_DEPTH-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wren) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH), .SIZE(32)) dut (
    .clock        (clk),
    .reset        (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_wren     (ram_wren),
    .ram_data_out (ram_data_out)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat, input int exp_wr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge after the response pulse.
  task automatic run(input vec_t v, input int idx);
    int lat;
    int wr;
    logic [31:0] rd;
    logic        er;
    lat = 0; wr = 0; rd = 'x; er = 1'bx;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    chk($sformatf("v%0d ready_before", idx), {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~v.we; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ram_wren) wr++;
      if (n == 1) chk($sformatf("v%0d ready_busy", idx), {31'd0, req_ready}, 32'd0);
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.exp_err});
    chk($sformatf("v%0d wren_cycles", idx), wr, v.exp_wr);
    @(negedge clk);
    chk($sformatf("v%0d single_pulse", idx), {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;

    tv.push_back(mk(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1));
    tv.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0));
    tv.push_back(mk(1, 3'b000, 32'h11,   32'hFFFFFF55, 32'h0,        0, 3, 1));
    tv.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 0, 2, 0));
    tv.push_back(mk(0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0, 2, 0));
    tv.push_back(mk(0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0, 2, 0));
    tv.push_back(mk(0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 0, 2, 0));
    tv.push_back(mk(0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 0, 2, 0));
    tv.push_back(mk(0, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, 0, 2, 0));
    tv.push_back(mk(0, 3'b100, 32'h11,   32'h0,        32'h00000055, 0, 2, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    tv.push_back(mk(0, 3'b010, 32'h12,   32'h0,        32'h0,        1, 1, 0));
`else
    tv.push_back(mk(0, 3'b010, 32'h12,   32'h0,        32'hDEAD55EF, 0, 2, 0));
`endif
    tv.push_back(mk(1, 3'b010, 32'h14,   32'h11112222, 32'h0,        0, 2, 1));
    tv.push_back(mk(1, 3'b001, 32'h16,   32'hABCD1234, 32'h0,        0, 3, 1));
    tv.push_back(mk(0, 3'b010, 32'h14,   32'h0,        32'h12342222, 0, 2, 0));
    tv.push_back(mk(0, 3'b001, 32'h14,   32'h0,        32'h00002222, 0, 2, 0));
    tv.push_back(mk(1, 3'b010, 32'h1010, 32'hCAFEF00D, 32'h0,        0, 2, 1));
    tv.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'hCAFEF00D, 0, 2, 0));
    tv.push_back(mk(0, 3'b011, 32'h10,   32'h0,        32'h0,        1, 1, 0));
    tv.push_back(mk(1, 3'b100, 32'h10,   32'h0,        32'h0,        1, 1, 0));
    tv.push_back(mk(1, 3'b111, 32'h10,   32'h12345678, 32'h0,        1, 1, 0));
    tv.push_back(mk(0, 3'b010, 32'h10,   32'h0,        32'hCAFEF00D, 0, 2, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    tv.push_back(mk(0, 3'b001, 32'h11,   32'h0,        32'h0,        1, 1, 0));
`else
    tv.push_back(mk(0, 3'b001, 32'h11,   32'h0,        32'hFFFFF00D, 0, 2, 0));
`endif
    tv.push_back(mk(0, 3'b010, 32'h4010, 32'h0,        32'hCAFEF00D, 0, 2, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready",    {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err",  {31'd0, rsp_err}, 32'd0);
    chk("reset ram_wren", {31'd0, ram_wren}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) run(tv[i], i);

    chk("mem4 after table", mem[4], 32'hCAFEF00D);
    chk("mem5 after table", mem[5], 32'h12342222);

    // Reset while an SB sits in WR must abort the write and the response.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort in_wr", {31'd0, ram_wren}, 32'd1);
    rst = 1'b1;
    #1 chk("abort wren_gated", {31'd0, ram_wren}, 32'd0);
    @(negedge clk);
    chk("abort ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort no_rsp", seen, 0);
    chk("abort mem4", mem[4], 32'hCAFEF00D);
    run(mk(0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 0, 2, 0), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be MEM_DEPTH (default 1024, RAM depth in 32-bit words) and SIZE (default 32, data width); ADDR_W = $clog2(MEM_DEPTH).
REQ-002 clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  CPU access request.
REQ-005 req_ready  out  1  unit idle and able to accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  SIZE  store data, LSB-aligned.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  SIZE  load result, extended; valid only with rsp_valid.
REQ-012 rsp_err  out  1  illegal funct3 or misaligned access; valid only with rsp_valid.
REQ-013 ram_address  out  ADDR_W  word index to RAM.
REQ-014 ram_data_in  out  SIZE  RAM write data.
REQ-015 ram_wren  out  1  RAM write enable, sampled by the RAM on posedge clock.
REQ-016 ram_data_out  in  SIZE  RAM combinational (same-cycle) read data.

Function
REQ-017 FSM states SHALL be IDLE, RD, WR, DONE; req_ready = 1 only in IDLE.
REQ-018 Accept on posedge with req_valid && req_ready; request fields latched; inputs ignored outside IDLE.
REQ-019 Word index = latched addr[ADDR_W+1:2]; higher bits ignored (wraps modulo MEM_DEPTH).
REQ-020 From IDLE on accept: loads and SB/SH stores -> RD; SW -> WR; illegal funct3 or error -> DONE.
REQ-021 RD: ram_address driven, ram_data_out captured at posedge; load -> DONE, sub-word store -> WR.
REQ-022 WR: ram_wren = 1 for exactly one cycle; ram_data_in = req_wdata (SW) or captured word with addressed byte/half lane replaced (SB/SH); -> DONE.
REQ-023 DONE: rsp_valid = 1 one cycle, then IDLE; ram_wren = 0 in every state except WR.
REQ-024 Latency accept-edge to rsp_valid: LW/LB/LH/LBU/LHU and SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
REQ-025 Load extract: byte lane = addr[1:0], half lane = addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-026 Illegal funct3 (011, 110, 111, or stores with 1xx): no RAM write, rsp_rdata = 0, rsp_err = 1.
REQ-027 rsp_rdata = 0 on store completions; rsp_err = 0 on legal completions.

Reset
REQ-028 reset high at posedge SHALL force IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, captured word = 0.
REQ-029 ram_wren SHALL be gated combinationally by reset (0 whenever reset = 1), so reset in WR aborts the write.
REQ-030 An aborted in-flight request SHALL produce no rsp_valid.

Configuration
REQ-031 Macro LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0] = 1 or W with addr[1:0] != 0 -> DONE with rsp_err = 1, no RAM write, rsp_rdata = 0.
REQ-032 Macro undefined: no alignment check; H uses addr[1], W ignores addr[1:0]; rsp_err only for illegal funct3.

Structure
REQ-033 Package lsu_pkg SHALL hold the funct3 encoding constants and the FSM state enum typedef.
REQ-034 Combinational lane extract/merge/extension SHALL be sub-module lsu_align; FSM and registers remain in load_store_unit.

Verification
REQ-035 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ram_wren one cycle at word 4; rsp_rdata 0xDEADBEEF, rsp_valid 2 cycles after accept.
REQ-036 Word 4 = 0xDEADBEEF; SB addr 0x11 data 0x55 -> word 4 = 0xDEAD55EF, rsp_valid 3 cycles after accept.
REQ-037 Word 4 = 0xDEAD55EF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
REQ-038 LW 0x12 with LSU_MISALIGN_CHECK_EN -> rsp_err = 1, rdata 0, 1-cycle latency; without macro -> word 4 data, rsp_err = 0.
REQ-039 SB accepted, reset asserted during WR -> ram_wren stays 0, word unchanged, no rsp_valid, req_ready = 1 after reset.
REQ-040 SW addr 0x1010 (MEM_DEPTH 1024) -> writes word 4 (wrap); funct3 011 -> rsp_err = 1, no write.
